// File: rtl/seq_magnitude_comparator_if.sv
// seq_magnitude_comparator_if
//   Bundles the operand and result handshakes of the sequential magnitude
//   comparator. Clock and reset are not part of the bundle.
//   Signals:
//     in_valid / in_ready   operand handshake (a, b, is_signed qualified by in_valid)
//     a, b                  WIDTH-bit operands
//     is_signed             1: two's-complement compare, 0: unsigned compare
//     out_valid / out_ready result handshake (lt, gt, eq qualified by out_valid)
//     lt, gt, eq            one-hot compare result while out_valid is high
//   Modports:
//     master  the producer/consumer side (testbench or neighbouring stages)
//     slave   the comparator itself
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             lt;
  logic             gt;
  logic             eq;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, lt, gt, eq
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, lt, gt, eq
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator
//   Multi-cycle WIDTH-bit magnitude comparator with a runtime signed/unsigned
//   mode. Operands are walked MSB-first, DIGIT bits per cycle, and the walk
//   stops at the first digit that differs. Result latency after the accept
//   edge is the 1-based position of that digit (N = WIDTH/DIGIT when equal).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    slave side of seq_magnitude_comparator_if (operand and result
//            valid/ready handshakes, a, b, is_signed, lt, gt, eq)
//   Every output is a flop; nothing combinational reaches the interface.
module seq_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  seq_magnitude_comparator_if.slave   bus
);

  localparam int N   = WIDTH / DIGIT;
  localparam int K_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_q, a_n;
  logic [WIDTH-1:0] b_q, b_n;
  logic [K_W-1:0]   k_q, k_n;
  logic             lt_q, lt_n;
  logic             gt_q, gt_n;
  logic             eq_q, eq_n;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [DIGIT-1:0] digit_a;
  logic [DIGIT-1:0] digit_b;

  // Select the digit currently under examination. A loop over constant
  // offsets keeps the part-selects static.
  always_comb begin
    digit_a = '0;
    digit_b = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == i[K_W-1:0]) begin
        digit_a = a_q[i*DIGIT +: DIGIT];
        digit_b = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  // Next-state and next-data logic. Flipping both MSBs when is_signed is set
  // maps two's-complement order onto unsigned order, so the mode needs no
  // storage of its own after capture.
  always_comb begin
    next_state = state;
    a_n        = a_q;
    b_n        = b_q;
    k_n        = k_q;
    lt_n       = lt_q;
    gt_n       = gt_q;
    eq_n       = eq_q;
    unique case (state)
      IDLE: begin
        if (in_ready_q && bus.in_valid) begin
          a_n        = {bus.a[WIDTH-1] ^ bus.is_signed, bus.a[WIDTH-2:0]};
          b_n        = {bus.b[WIDTH-1] ^ bus.is_signed, bus.b[WIDTH-2:0]};
          k_n        = K_W'(N - 1);
          next_state = COMPARE;
        end
      end
      COMPARE: begin
        if (digit_a < digit_b) begin
          lt_n       = 1'b1;
          next_state = DONE;
        end else if (digit_a > digit_b) begin
          gt_n       = 1'b1;
          next_state = DONE;
        end else if (k_q == '0) begin
          eq_n       = 1'b1;
          next_state = DONE;
        end else begin
          k_n = k_q - K_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          lt_n       = 1'b0;
          gt_n       = 1'b0;
          eq_n       = 1'b0;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State and datapath registers. in_ready and out_valid are registered
  // decodes of the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= next_state;
      a_q         <= a_n;
      b_q         <= b_n;
      k_q         <= k_n;
      lt_q        <= lt_n;
      gt_q        <= gt_n;
      eq_q        <= eq_n;
      in_ready_q  <= (next_state == IDLE);
      out_valid_q <= (next_state == DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.lt        = lt_q;
  assign bus.gt        = gt_q;
  assign bus.eq        = eq_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator
//   Self-checking bench for seq_magnitude_comparator (WIDTH=8, DIGIT=2).
//   Expected results come from a $signed/$unsigned reference compare and the
//   expected latency from the position of the first differing 2-bit digit.
module tb_seq_magnitude_comparator;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int N     = WIDTH / DIGIT;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  seq_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

  seq_magnitude_comparator #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference result as {lt, gt, eq}.
  function automatic logic [2:0] refResult(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic s);
    logic signed [WIDTH-1:0] sa, sb;
    sa = a;
    sb = b;
    if (s) begin
      if (sa < sb)      return 3'b100;
      else if (sa > sb) return 3'b010;
      else              return 3'b001;
    end else begin
      if (a < b)        return 3'b100;
      else if (a > b)   return 3'b010;
      else              return 3'b001;
    end
  endfunction

  // Reference latency: 1-based position of the first differing digit from
  // the MSB, N when the operands are identical.
  function automatic int refLatency(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    d = a ^ b;
    for (int j = 1; j <= N; j++) begin
      if (((d >> (WIDTH - j * DIGIT)) & ((1 << DIGIT) - 1)) != 0) return j;
    end
    return N;
  endfunction

  function automatic logic [2:0] flags();
    return {bus.lt, bus.gt, bus.eq};
  endfunction

  // Waits (bounded) for in_ready. Called #1 after an active edge.
  task automatic waitReady();
    int n;
    n = 0;
    while (!bus.in_ready && n < 2 * N + 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("in_ready_wait", 32'(bus.in_ready), 32'd1);
  endtask

  // One full transaction: accept, wait for the result, stall with garbage on
  // the input side, then hand the result off. Returns the observed latency.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic s, input int stall, output int lat);
    logic [2:0] exp_res;
    int         exp_lat;
    exp_res = refResult(a, b, s);
    exp_lat = refLatency(a, b);
    waitReady();
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    // Scramble inputs after capture; the block must ignore them.
    bus.in_valid  = 1'b0;
    bus.a         = WIDTH'($urandom);
    bus.b         = WIDTH'($urandom);
    bus.is_signed = 1'($urandom);
    lat = 0;
    while (lat <= N + 2) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) break;
      if (flags() != 3'b000) checkOutput("flags_while_busy", 32'(flags()), 32'd0);
    end
    checkOutput("out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("result", 32'(flags()), 32'(exp_res));
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'($urandom);
      bus.a        = WIDTH'($urandom);
      bus.b        = WIDTH'($urandom);
      @(posedge clk);
      #1;
      checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("stall_result", 32'(flags()), 32'(exp_res));
      checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("release_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("release_flags", 32'(flags()), 32'd0);
    checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int         lat;
    logic [7:0] ra, rb;
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_flags", 32'(flags()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed cases with hand-derived latencies.
    applyStimulus(8'h35, 8'h53, 1'b0, 0, lat);
    checkOutput("t1_latency", 32'(lat), 32'd1);
    applyStimulus(8'hA5, 8'hA5, 1'b0, 1, lat);
    checkOutput("t2_eq_latency", 32'(lat), 32'd4);
    applyStimulus(8'hA4, 8'hA5, 1'b0, 0, lat);
    checkOutput("t2_lt_latency", 32'(lat), 32'd4);
    applyStimulus(8'h80, 8'h7F, 1'b1, 0, lat);
    applyStimulus(8'h80, 8'h7F, 1'b0, 0, lat);
    applyStimulus(8'hFF, 8'h01, 1'b1, 0, lat);
    applyStimulus(8'h90, 8'h10, 1'b0, 5, lat);

    // Reset during the second COMPARE cycle of an equal-operand compare.
    waitReady();
    bus.in_valid  = 1'b1;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.is_signed = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("abort_flags", 32'(flags()), 32'd0);
    repeat (N + 2) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) checkOutput("abort_no_result", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) checkOutput("post_reset_no_result", 32'(bus.out_valid), 32'd0);
    end
    applyStimulus(8'h07, 8'h03, 1'b0, 0, lat);

    // Random sweep, biased towards equal or shared-prefix operands.
    for (int t = 0; t < 1000; t++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = ra;
        1:       rb = {ra[7:2], rb[1:0]};
        2:       rb = {ra[7:4], rb[3:0]};
        default: ;
      endcase
      applyStimulus(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
